// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Latency: none (wires only); one request may be outstanding at a time.
// Backpressure: imem_gnt accepts a request; imem_rvalid returns its single response.
// Signals: imem_req/imem_addr (fetch -> mem), imem_gnt/imem_rvalid/imem_rdata (mem -> fetch).
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, one-outstanding imem handshake, skid entry, IF/ID register.
// Latency: IF/ID valid 2 edges after a grant when rvalid follows gnt; peak 1 instr / 2 cycles.
// Backpressure: stall holds IF/ID; a response arriving while the slot is busy parks in the skid.
// Ports: clk, rst_n (async active-low); imem (master modport of if_fetch_stage_if);
//        stall/flush/redirect/redirect_pc from later stages; if_id_valid/if_id_pc/if_id_inst to decode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    if_fetch_stage_if.master        imem,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    if_id_valid,
    output logic [31:0]             if_id_pc,
    output logic [31:0]             if_id_inst
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        kill;
    logic        req_q;

    logic        slot_free;
    logic        granted;
    logic        rsp;
    logic        load_rsp;
    logic        load_skid;
    logic [31:0] redirect_tgt;

    // Decode takes the current entry on any edge with valid && !stall; flush blocks any load.
    assign slot_free    = (!if_id_valid || !stall) && !flush;
    assign redirect_tgt = redirect_pc & ~32'h3;
    // req_q is low for the first FETCH cycle after reset, so a stray gnt then is ignored.
    assign granted      = (state == FETCH) && req_q && imem.imem_gnt;
    // rvalid outside WAIT is a protocol error and is ignored.
    assign rsp          = (state == WAIT) && imem.imem_rvalid;
    assign load_rsp     = rsp && !kill && !redirect && slot_free;
    assign load_skid    = (state == HOLD) && !redirect && slot_free;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            skid_pc     <= 32'h0;
            skid_inst   <= NOP_INST;
            kill        <= 1'b0;
            req_q       <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'h0;
            if_id_inst  <= NOP_INST;
        end else begin
            // IF/ID slot
            if (load_rsp) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_pc;
                if_id_inst  <= imem.imem_rdata;
            end else if (load_skid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= skid_pc;
                if_id_inst  <= skid_inst;
            end else if (flush || (if_id_valid && !stall)) begin
                if_id_valid <= 1'b0;
                if_id_inst  <= NOP_INST;
            end

            // PC: redirect overrides the sequential increment
            if (redirect) begin
                pc <= redirect_tgt;
            end else if (granted) begin
                pc <= pc + 32'd4;
            end

            case (state)
                FETCH: begin
                    if (granted) begin
                        req_pc <= pc;
                        // A redirect in the grant cycle makes this request stale.
                        kill   <= redirect;
                        req_q  <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        req_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rsp) begin
                        kill <= 1'b0;
                        if (redirect || kill || slot_free) begin
                            // dropped (stale) or loaded straight into IF/ID
                            req_q <= 1'b1;
                            state <= FETCH;
                        end else begin
                            skid_pc   <= req_pc;
                            skid_inst <= imem.imem_rdata;
                            state     <= HOLD;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    // redirect discards the parked entry
                    if (redirect || slot_free) begin
                        req_q <= 1'b1;
                        state <= FETCH;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    if_fetch_stage_if bus();

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_pass;
    logic [63:0] sb_q[$];
    // memory model state
    logic        gnt_en;
    logic        rsp_go;
    logic        pend;
    logic [31:0] pend_addr;
    int          drop_cnt;
    logic [31:0] forbid_pc;
    int          forbid_hits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at negedge: drive memory, score, advance.
    task automatic tick();
        logic        g;
        logic        rv;
        logic [31:0] a;
        logic [63:0] e;
        bus.imem_gnt    = bus.imem_req && gnt_en;
        rv              = pend && rsp_go;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? (pend_addr ^ KEY) : 32'h0;
        if (rv) begin
            if (drop_cnt > 0) drop_cnt--;
            else sb_q.push_back({pend_addr, pend_addr ^ KEY});
        end
        if (if_id_valid && if_id_pc == forbid_pc) forbid_hits++;
        if (rst_n && if_id_valid && !stall && !flush) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", if_id_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", if_id_pc, e[63:32]);
                chk("sb_inst", if_id_inst, e[31:0]);
            end
        end
        g = bus.imem_req && bus.imem_gnt;
        a = bus.imem_addr;
        @(posedge clk);
        if (rv) pend = 1'b0;
        if (g && rst_n) begin
            pend      = 1'b1;
            pend_addr = a;
        end
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_timeout", {31'h0, bus.imem_req}, 32'd1);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        gnt_en = 1'b1; rsp_go = 1'b1; pend = 1'b0; pend_addr = 32'h0;
        drop_cnt = 0; forbid_pc = 32'hDEAD_BEEF; forbid_hits = 0;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, if_id_valid}, 32'd0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_inst", if_id_inst, NOP);
        chk("rst_req", {31'h0, bus.imem_req}, 32'd0);
        rst_n = 1'b1;

        // sequential fetch, immediate gnt/rvalid
        wait_req();
        chk("first_addr", bus.imem_addr, 32'h0);
        tick();
        chk("lat_valid0", {31'h0, if_id_valid}, 32'd0);
        tick();
        chk("lat_valid1", {31'h0, if_id_valid}, 32'd1);
        chk("pc0", if_id_pc, 32'h0);
        chk("inst0", if_id_inst, 32'hA5A5_0000);
        tick();
        chk("toggle0", {31'h0, if_id_valid}, 32'd0);
        tick();
        chk("toggle1", {31'h0, if_id_valid}, 32'd1);
        chk("pc4", if_id_pc, 32'h4);

        // stall while pc=8 response arrives -> skid/HOLD
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", {31'h0, if_id_valid}, 32'd1);
            chk("stall_pc", if_id_pc, 32'h4);
        end
        chk("hold_req", {31'h0, bus.imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        chk("skid_pc", if_id_pc, 32'h8);
        chk("skid_inst", if_id_inst, 32'h8 ^ KEY);
        chk("after_hold_req", {31'h0, bus.imem_req}, 32'd1);
        chk("after_hold_addr", bus.imem_addr, 32'hC);

        // redirect while waiting for pc=16 (delayed response)
        tick();
        tick();
        chk("addr16", bus.imem_addr, 32'h10);
        tick();
        rsp_go = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        drop_cnt++; forbid_pc = 32'h10;
        tick();
        redirect = 1'b0; rsp_go = 1'b1;
        chk("kill_wait_req", {31'h0, bus.imem_req}, 32'd0);
        tick();
        chk("redir_req", {31'h0, bus.imem_req}, 32'd1);
        chk("redir_addr", bus.imem_addr, 32'h100);

        // flush coinciding with the response for 0x100
        tick();
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'h0, if_id_valid}, 32'd0);
        chk("flush_inst", if_id_inst, NOP);
        chk("flush_pc_adv", bus.imem_addr, 32'h104);
        flush = 1'b0;
        tick();
        chk("post_flush_pc", if_id_pc, 32'h100);

        // redirect in FETCH with grant in the same cycle
        chk("rf_req", {31'h0, bus.imem_req}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h40;
        drop_cnt++; forbid_pc = bus.imem_addr;
        tick();
        redirect = 1'b0;
        chk("rf_addr_wait", bus.imem_addr, 32'h40);
        tick();
        chk("rf_req2", {31'h0, bus.imem_req}, 32'd1);
        chk("rf_addr", bus.imem_addr, 32'h40);
        gnt_en = 1'b0;
        tick();
        tick();
        chk("rf_no_inc", bus.imem_addr, 32'h40);
        gnt_en = 1'b1;
        tick();
        chk("rf_inc", bus.imem_addr, 32'h44);
        tick();
        chk("rf_load_pc", if_id_pc, 32'h40);

        // reset while the 0x44 response is outstanding
        tick();
        rsp_go = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, if_id_valid}, 32'd0);
        chk("mid_rst_pc", if_id_pc, 32'h0);
        chk("mid_rst_inst", if_id_inst, NOP);
        chk("mid_rst_req", {31'h0, bus.imem_req}, 32'd0);
        drop_cnt++; forbid_pc = 32'h44; rsp_go = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        wait_req();
        chk("restart_addr", bus.imem_addr, 32'h0);
        repeat (8) tick();
        gnt_en = 1'b0;
        repeat (6) tick();
        chk("drain_sb", sb_q.size(), 32'd0);
        chk("drain_drops", drop_cnt, 32'd0);
        chk("stale_seen", forbid_hits, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction fetch stage with PC register, single-outstanding instruction-memory handshake, one-entry skid buffer and IF/ID pipeline register.
- Drives the instruction word and PC consumed by the decode stage: control decode, register file read and the immediate generator.
- Handles decode back-pressure (stall), pipeline flush and branch/jump redirect from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word presented when the IF/ID slot is empty (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; equals pc
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- stall  in  1  decode cannot accept a new instruction
- flush  in  1  invalidate IF/ID contents
- redirect  in  1  load new PC (taken branch/jump)
- redirect_pc  in  32  target PC
- if_id_valid  out  1  IF/ID slot holds a live instruction
- if_id_pc  out  32  PC of the IF/ID instruction
- if_id_inst  out  32  IF/ID instruction word

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=FETCH, kill=0, skid empty.
  - if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST, imem_req=0 while in reset.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt: pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 -> 0), go to WAIT.
  - Captured request PC is held internally as req_pc.
- WAIT:
  - imem_req=0. Only one request is ever outstanding.
  - On imem_rvalid with kill=1: discard, kill<=0, go to FETCH.
  - On imem_rvalid with kill=0 and slot free: load IF/ID with {req_pc, imem_rdata}, valid=1, go to FETCH.
  - On imem_rvalid with kill=0 and slot not free: store the response in the skid buffer, go to HOLD.
- HOLD:
  - imem_req=0.
  - When slot free: move skid contents into IF/ID, empty skid, go to FETCH.
- Slot free: (!if_id_valid || !stall) && !flush. The current entry is consumed by decode on any edge with if_id_valid=1 and stall=0; if nothing new loads, if_id_valid<=0 and if_id_inst<=NOP_INST.
- flush:
  - if_id_valid<=0, if_id_inst<=NOP_INST.
  - Wins over any simultaneous load.
  - Does not touch pc, skid or state.
- redirect (highest priority):
  - pc<={redirect_pc[31:2],2'b00}; the +4 increment is suppressed.
  - FETCH with gnt in the same cycle: go to WAIT with kill=1.
  - WAIT: kill<=1; a response arriving that same cycle is dropped.
  - HOLD: skid emptied, go to FETCH.
  - redirect does not clear IF/ID by itself; execute asserts flush alongside it.
- Latency:
  - Earliest if_id_valid is 2 edges after a grant (rvalid the cycle after gnt).
  - Peak throughput is one instruction per 2 cycles when gnt and rvalid are immediate.
- if_id_pc and if_id_inst are stable while stall=1 and if_id_valid=1.
- Reset mid-transaction: the outstanding response is ignored. The block restarts at RESET_PC in FETCH one cycle after rst_n rises.
- imem_rvalid in FETCH or HOLD is a protocol error and is ignored.

Test Plan:
- Reset release, gnt=1 always, rvalid one cycle after gnt, rdata=addr^32'hA5A5_0000 -> IF/ID shows pc 0,4,8 with matching inst; if_id_valid toggles 1 every other cycle; first valid 2 edges after first gnt.
- stall held 4 cycles while the slot holds pc=4 and the response for pc=8 arrives -> state HOLD, if_id unchanged (pc=4); stall drop -> pc=8 loaded the next edge, then FETCH of 12.
- redirect=1, redirect_pc=32'h0000_0103 while in WAIT for pc=16 -> the pc=16 response is dropped; next imem_addr=32'h0000_0100; IF/ID never shows pc=16.
- flush=1 coinciding with a response load -> if_id_valid=0, if_id_inst=32'h0000_0013 the next cycle; pc keeps advancing.
- redirect=1 in FETCH with gnt=1 same cycle, target 32'h40 -> that response is killed, the next request is at 0x40, and pc is not incremented past 0x40 before its grant.
- rst_n asserted low while in WAIT, rvalid arriving during reset -> outputs reset immediately; after release imem_addr=RESET_PC and the stale data never appears in IF/ID.
